i2c_slave: RTL and testbench
============================

// Module: i2c_slave
// PURPOSE
//  Byte-level I2C target front end for the bootloader. Oversamples SCL/SDA on clk, detects
//  START/STOP, matches a 7-bit address, shifts bytes in/out and drives ACK. Feeds i2c_fsm
//  (write bytes, transaction-start pulses) and pulls read bytes from it via valid/ready.
//  No clock stretching: clk must be >= 16x SCL frequency.
// PARAMETERS
//  ADDRESS      7'h42   7-bit target address
// PORTS
//  clk              in   1  system clock
//  rst              in   1  async active-high reset
//  scl_in           in   1  raw SCL pad input
//  sda_in           in   1  raw SDA pad input
//  sda_oe           out  1  1 = pull SDA low (open drain), 0 = release
//  i2c_write        out  1  1-cycle pulse: address matched, R/W=0
//  i2c_read         out  1  1-cycle pulse: address matched, R/W=1
//  i2c_write_data   out  8  received data byte
//  i2c_write_valid  out  1  write byte offered downstream
//  i2c_write_ready  in   1  downstream accepts write byte
//  i2c_read_data    in   8  next byte to transmit
//  i2c_read_valid   in   1  read byte available
//  i2c_read_ready   out  1  1-cycle pop of read byte
// BEHAVIOUR
//  - Reset (async): all outputs 0, sda_oe released immediately, state IDLE, shifters 0.
//  - scl/sda through 2-FF synchronizers + edge detect; all events use synced values
//    (3-cycle input latency). START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//  - States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
//  - START from any state (incl. repeated START) -> ADDR, bit count 0, sda_oe released.
//    STOP from any state -> IDLE. Data bits sampled on SCL rise, MSB first; SDA output
//    changed only on SCL fall.
//  - ADDR: on 8th SCL rise compare [7:1] to ADDRESS. Match: pulse i2c_write or i2c_read
//    (per bit 0) in the cycle after that rise; on next SCL fall assert sda_oe (ACK).
//    Mismatch: no pulse, no ACK, -> WAIT_STOP (ignore until START/STOP).
//  - Write path: ADDR_ACK -> (SCL fall ending ACK bit releases SDA) -> WR_BYTE. On 8th rise
//    latch i2c_write_data, raise i2c_write_valid. Held until valid&&ready (then dropped next
//    cycle). Accepted before next SCL fall -> ACK, -> WR_ACK -> WR_BYTE. Not accepted by
//    that fall -> valid dropped, byte discarded, NACK, -> WAIT_STOP.
//  - Read path: on SCL fall ending ADDR ACK: if i2c_read_valid, load shifter from
//    i2c_read_data and pulse i2c_read_ready 1 cycle; else load 8'hFF, no pulse. Drive
//    sda_oe = ~bit (MSB first) on each fall; release SDA on fall after 8th bit (RD_ACK).
//    On 9th rise: SDA low (master ACK) -> load next byte same rule on following fall,
//    -> RD_BYTE; SDA high (NACK) -> WAIT_STOP, no further pops.
//  - Exactly one i2c_read_ready pulse per byte actually loaded; never two per byte.
//  - Bit counter 4 bits, wraps 0..8 per byte; shifter 8 bits.
//  - SCL glitches shorter than 2 clk are not required to be filtered.
// STRUCTURE
//  - i2c_defs.vh (shared include): state encodings, ACK/NACK constants, default ADDRESS.
//  - Sub-module i2c_sync_edge: 2-FF synchronizer + rise/fall detect, one instance each for
//    SCL and SDA. Remaining logic (FSM, shifter, counters) in i2c_slave.
// TESTING
//  - Write: START,0x84,0x11,0x22,STOP, ready=1 -> i2c_write 1 pulse; 3 ACKs; write_valid
//    with 0x11 then 0x22; no read pulse.
//  - Mismatch: START,0x86,0xAA,STOP -> sda_oe stays 0 throughout; no pulses/valid.
//  - Read: START,0x85, model bytes 0x80,0xA5,0x3C, master ACK,ACK,NACK -> SDA carries
//    those bytes; i2c_read 1 pulse; exactly 3 i2c_read_ready pulses.
//  - Backpressure: write byte 0x5A with ready=0 -> NACK on 9th bit; valid drops; further
//    bytes ignored until START.
//  - Repeated START: write 0x84,0x01 then Sr,0x85 -> i2c_write then i2c_read pulse; read
//    with read_valid=0 sends 0xFF, no ready pulse.
//  - Reset asserted while sda_oe=1 (ACK phase) -> sda_oe 0 same cycle; next START works.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types and constants for the I2C target front end.
package i2c_slave_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned ADDR_W = 7;

   localparam logic [ADDR_W-1:0] DEFAULT_ADDRESS = 7'h42;

   // sda_oe levels: pulling low is an ACK, releasing reads as NACK
   localparam logic OE_ACK  = 1'b1;
   localparam logic OE_NACK = 1'b0;
   localparam logic BUS_ACK = 1'b0;

   localparam logic [BYTE_W-1:0] IDLE_BYTE = 8'hFF;
   localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(7);
   localparam logic [CNT_W-1:0]  BYTE_DONE = CNT_W'(8);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_BYTE,
      ST_WR_ACK,
      ST_RD_BYTE,
      ST_RD_ACK,
      ST_WAIT_STOP
   } state_t;

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      return CNT_W'(c + CNT_W'(1));
   endfunction

endpackage

// File: rtl/i2c_slave_sync_edge.sv
// Two-flop synchronizer for a pad input plus rise/fall detection on the synced value.
module i2c_slave_sync_edge #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic sync_o,
   output logic rise_c,
   output logic fall_c
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Reset to the idle bus level so release from reset creates no edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
         prev_q <= RST_VAL;
      end else begin
         meta_q <= raw_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_o = sync_q;
   assign rise_c = sync_q & ~prev_q;
   assign fall_c = ~sync_q & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// Byte-level I2C target: START/STOP detect, address match, byte shift in/out and ACK drive.
module i2c_slave
   import i2c_slave_pkg::*;
#(
   parameter logic [ADDR_W-1:0] ADDRESS = DEFAULT_ADDRESS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl_in,
   input  logic              sda_in,
   output logic              sda_oe,
   output logic              i2c_write,
   output logic              i2c_read,
   output logic [BYTE_W-1:0] i2c_write_data,
   output logic              i2c_write_valid,
   input  logic              i2c_write_ready,
   input  logic [BYTE_W-1:0] i2c_read_data,
   input  logic              i2c_read_valid,
   output logic              i2c_read_ready
);

   logic scl_s, scl_rise_c, scl_fall_c;
   logic sda_s, sda_rise_c, sda_fall_c;
   logic start_c, stop_c;
   logic [BYTE_W-1:0] load_byte_c;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BYTE_W-1:0] shift_q, shift_d;
   logic [BYTE_W-1:0] wdata_q, wdata_d;
   logic              sda_oe_q, sda_oe_d;
   logic              wr_pulse_q, wr_pulse_d;
   logic              rd_pulse_q, rd_pulse_d;
   logic              wvalid_q, wvalid_d;
   logic              rready_q, rready_d;
   logic              rw_q, rw_d;
   logic              acc_q, acc_d;
   logic              ph_q, ph_d;

   i2c_slave_sync_edge u_scl_sync (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (scl_in),
      .sync_o (scl_s),
      .rise_c (scl_rise_c),
      .fall_c (scl_fall_c)
   );

   i2c_slave_sync_edge u_sda_sync (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (sda_in),
      .sync_o (sda_s),
      .rise_c (sda_rise_c),
      .fall_c (sda_fall_c)
   );

   assign start_c     = sda_fall_c & scl_s;
   assign stop_c      = sda_rise_c & scl_s;
   assign load_byte_c = i2c_read_valid ? i2c_read_data : IDLE_BYTE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         wdata_q    <= '0;
         sda_oe_q   <= OE_NACK;
         wr_pulse_q <= 1'b0;
         rd_pulse_q <= 1'b0;
         wvalid_q   <= 1'b0;
         rready_q   <= 1'b0;
         rw_q       <= 1'b0;
         acc_q      <= 1'b0;
         ph_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         wdata_q    <= wdata_d;
         sda_oe_q   <= sda_oe_d;
         wr_pulse_q <= wr_pulse_d;
         rd_pulse_q <= rd_pulse_d;
         wvalid_q   <= wvalid_d;
         rready_q   <= rready_d;
         rw_q       <= rw_d;
         acc_q      <= acc_d;
         ph_q       <= ph_d;
      end
   end

   // ph_q marks the second half of an ACK slot (ACK driven / master ACK seen)
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      wdata_d    = wdata_q;
      sda_oe_d   = sda_oe_q;
      wr_pulse_d = 1'b0;
      rd_pulse_d = 1'b0;
      wvalid_d   = wvalid_q;
      rready_d   = 1'b0;
      rw_d       = rw_q;
      acc_d      = acc_q;
      ph_d       = ph_q;

      if (wvalid_q && i2c_write_ready) begin
         wvalid_d = 1'b0;
         acc_d    = 1'b1;
      end

      if (start_c) begin
         state_d  = ST_ADDR;
         cnt_d    = '0;
         shift_d  = '0;
         sda_oe_d = OE_NACK;
         wvalid_d = 1'b0;
         acc_d    = 1'b0;
         ph_d     = 1'b0;
      end else if (stop_c) begin
         state_d  = ST_IDLE;
         cnt_d    = '0;
         sda_oe_d = OE_NACK;
         wvalid_d = 1'b0;
         acc_d    = 1'b0;
         ph_d     = 1'b0;
      end else begin
         unique case (state_q)
            ST_ADDR: begin
               if (scl_rise_c) begin
                  shift_d = {shift_q[BYTE_W-2:0], sda_s};
                  cnt_d   = cnt_inc(cnt_q);
                  if (cnt_q == LAST_BIT) begin
                     cnt_d = '0;
                     ph_d  = 1'b0;
                     if (shift_q[ADDR_W-1:0] == ADDRESS) begin
                        rw_d       = sda_s;
                        wr_pulse_d = ~sda_s;
                        rd_pulse_d = sda_s;
                        state_d    = ST_ADDR_ACK;
                     end else begin
                        state_d = ST_WAIT_STOP;
                     end
                  end
               end
            end

            ST_ADDR_ACK: begin
               if (scl_fall_c) begin
                  if (!ph_q) begin
                     sda_oe_d = OE_ACK;
                     ph_d     = 1'b1;
                  end else begin
                     ph_d  = 1'b0;
                     cnt_d = '0;
                     if (rw_q) begin
                        shift_d  = load_byte_c;
                        rready_d = i2c_read_valid;
                        sda_oe_d = ~load_byte_c[BYTE_W-1];
                        state_d  = ST_RD_BYTE;
                     end else begin
                        sda_oe_d = OE_NACK;
                        state_d  = ST_WR_BYTE;
                     end
                  end
               end
            end

            ST_WR_BYTE: begin
               if (scl_rise_c) begin
                  shift_d = {shift_q[BYTE_W-2:0], sda_s};
                  cnt_d   = cnt_inc(cnt_q);
                  if (cnt_q == LAST_BIT) begin
                     cnt_d    = '0;
                     wdata_d  = {shift_q[BYTE_W-2:0], sda_s};
                     wvalid_d = 1'b1;
                     acc_d    = 1'b0;
                     ph_d     = 1'b0;
                     state_d  = ST_WR_ACK;
                  end
               end
            end

            // An unaccepted byte is dropped and NACKed; the rest of the transfer is ignored
            ST_WR_ACK: begin
               if (scl_fall_c) begin
                  if (!ph_q) begin
                     if (acc_q || (wvalid_q && i2c_write_ready)) begin
                        sda_oe_d = OE_ACK;
                        ph_d     = 1'b1;
                     end else begin
                        wvalid_d = 1'b0;
                        sda_oe_d = OE_NACK;
                        state_d  = ST_WAIT_STOP;
                     end
                  end else begin
                     sda_oe_d = OE_NACK;
                     ph_d     = 1'b0;
                     cnt_d    = '0;
                     state_d  = ST_WR_BYTE;
                  end
               end
            end

            ST_RD_BYTE: begin
               if (scl_rise_c) begin
                  cnt_d = cnt_inc(cnt_q);
               end else if (scl_fall_c) begin
                  if (cnt_q == BYTE_DONE) begin
                     sda_oe_d = OE_NACK;
                     cnt_d    = '0;
                     ph_d     = 1'b0;
                     state_d  = ST_RD_ACK;
                  end else begin
                     shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
                     sda_oe_d = ~shift_q[BYTE_W-2];
                  end
               end
            end

            ST_RD_ACK: begin
               if (scl_rise_c && !ph_q) begin
                  if (sda_s == BUS_ACK) begin
                     ph_d = 1'b1;
                  end else begin
                     state_d = ST_WAIT_STOP;
                  end
               end else if (scl_fall_c && ph_q) begin
                  shift_d  = load_byte_c;
                  rready_d = i2c_read_valid;
                  sda_oe_d = ~load_byte_c[BYTE_W-1];
                  ph_d     = 1'b0;
                  cnt_d    = '0;
                  state_d  = ST_RD_BYTE;
               end
            end

            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   assign sda_oe          = sda_oe_q;
   assign i2c_write       = wr_pulse_q;
   assign i2c_read        = rd_pulse_q;
   assign i2c_write_data  = wdata_q;
   assign i2c_write_valid = wvalid_q;
   assign i2c_read_ready  = rready_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-banged I2C master, read-byte model and scoreboards.
module tb_i2c_slave;

   localparam int Q = 5;  // clk cycles per quarter SCL period

   logic       clk;
   logic       rst;
   logic       scl_m;
   logic       sda_m;
   logic       sda_bus;
   logic       sda_oe;
   logic       i2c_write;
   logic       i2c_read;
   logic [7:0] i2c_write_data;
   logic       i2c_write_valid;
   logic       i2c_write_ready;
   logic [7:0] i2c_read_data;
   logic       i2c_read_valid;
   logic       i2c_read_ready;

   typedef struct {
      logic [7:0]      addr;
      int              n;
      logic [2:0][7:0] d;
      logic            ready;
      logic [3:0]      acks;
      int              wr;
      int              rd;
      int              rdy;
      int              vr;
      logic            oe_any;
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;

   int c_wr = 0, c_rd = 0, c_rdy = 0, c_vr = 0, c_oe = 0;
   logic valid_prev = 1'b0;

   logic [7:0] rmem [64];
   logic [5:0] rwp = '0;
   logic [5:0] rrp = '0;
   logic [7:0] obs_mem [64];
   logic [5:0] owp = '0;
   logic [5:0] orp = '0;
   logic [7:0] exp_wq [$];
   logic [7:0] exp_rq [$];
   logic       last_sample;

   assign sda_bus        = sda_m & ~sda_oe;
   assign i2c_read_valid = (rrp != rwp);
   assign i2c_read_data  = rmem[rrp];

   i2c_slave dut (
      .clk             (clk),
      .rst             (rst),
      .scl_in          (scl_m),
      .sda_in          (sda_bus),
      .sda_oe          (sda_oe),
      .i2c_write       (i2c_write),
      .i2c_read        (i2c_read),
      .i2c_write_data  (i2c_write_data),
      .i2c_write_valid (i2c_write_valid),
      .i2c_write_ready (i2c_write_ready),
      .i2c_read_data   (i2c_read_data),
      .i2c_read_valid  (i2c_read_valid),
      .i2c_read_ready  (i2c_read_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observe DUT outputs mid-cycle: pulse counts, handshakes, read-model pops
   always @(negedge clk) begin
      if (i2c_write)      c_wr++;
      if (i2c_read)       c_rd++;
      if (sda_oe)         c_oe++;
      if (i2c_read_ready) begin
         c_rdy++;
         rrp = rrp + 6'd1;
      end
      if (i2c_write_valid && !valid_prev) c_vr++;
      valid_prev = i2c_write_valid;
      if (i2c_write_valid && i2c_write_ready) begin
         obs_mem[owp] = i2c_write_data;
         owp = owp + 6'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic qwait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b);
      sda_m = b;
      qwait(Q);
      scl_m = 1'b1;
      qwait(Q);
      last_sample = sda_bus;
      qwait(Q);
      scl_m = 1'b0;
      qwait(Q);
   endtask

   task automatic i2c_start();
      sda_m = 1'b1;
      qwait(Q);
      scl_m = 1'b1;
      qwait(Q);
      sda_m = 1'b0;
      qwait(Q);
      scl_m = 1'b0;
      qwait(Q);
   endtask

   task automatic i2c_stop();
      sda_m = 1'b0;
      qwait(Q);
      scl_m = 1'b1;
      qwait(Q);
      sda_m = 1'b1;
      qwait(2 * Q);
   endtask

   task automatic wbyte(input logic [7:0] b, output logic ack);
      for (int i = 7; i >= 0; i--) bit_xfer(b[i]);
      bit_xfer(1'b1);
      ack = last_sample;
   endtask

   task automatic rbyte(input logic nack, output logic [7:0] b);
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1);
         b[i] = last_sample;
      end
      bit_xfer(nack);
   endtask

   task automatic check_writes(input string name);
      logic [7:0] e;
      while (exp_wq.size() > 0) begin
         e = exp_wq.pop_front();
         if (orp != owp) begin
            chk($sformatf("%s_wdata", name), 32'(obs_mem[orp]), 32'(e));
            orp = orp + 6'd1;
         end else begin
            chk($sformatf("%s_wdata_missing", name), 32'h100, 32'(e));
         end
      end
      chk($sformatf("%s_no_extra_wdata", name), 32'(owp - orp), 32'd0);
      orp = owp;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int   wr0, rd0, rdy0, vr0, oe0;
      logic is_rd, match, ack;
      logic [7:0] got;
      wr0 = c_wr; rd0 = c_rd; rdy0 = c_rdy; vr0 = c_vr; oe0 = c_oe;
      i2c_write_ready = v.ready;
      is_rd = v.addr[0];
      match = (v.addr[7:1] == 7'h42);
      if (is_rd) begin
         for (int i = 0; i < v.n; i++) begin
            rmem[rwp] = v.d[i];
            rwp = rwp + 6'd1;
            exp_rq.push_back(v.d[i]);
         end
      end
      i2c_start();
      wbyte(v.addr, ack);
      chk($sformatf("%s_addr_ack", name), 32'(ack), 32'(v.acks[0]));
      for (int i = 0; i < v.n; i++) begin
         if (!is_rd) begin
            wbyte(v.d[i], ack);
            chk($sformatf("%s_d%0d_ack", name, i), 32'(ack), 32'(v.acks[i+1]));
            if (match && v.ready) exp_wq.push_back(v.d[i]);
         end else begin
            rbyte(i == v.n - 1, got);
            chk($sformatf("%s_rdata%0d", name, i), 32'(got), 32'(exp_rq.pop_front()));
         end
      end
      i2c_stop();
      chk($sformatf("%s_wr_pulses", name), 32'(c_wr - wr0), 32'(v.wr));
      chk($sformatf("%s_rd_pulses", name), 32'(c_rd - rd0), 32'(v.rd));
      chk($sformatf("%s_ready_pulses", name), 32'(c_rdy - rdy0), 32'(v.rdy));
      chk($sformatf("%s_valid_rises", name), 32'(c_vr - vr0), 32'(v.vr));
      chk($sformatf("%s_oe_any", name), 32'((c_oe - oe0) > 0), 32'(v.oe_any));
      chk($sformatf("%s_valid_idle", name), 32'(i2c_write_valid), 32'd0);
      chk($sformatf("%s_oe_idle", name), 32'(sda_oe), 32'd0);
      check_writes(name);
   endtask

   vec_t vecs [8];

   initial begin
      logic       ack;
      logic [7:0] got;
      int         wr0, rd0, rdy0;

      vecs[0] = '{8'h84, 2, {8'h00, 8'h22, 8'h11}, 1'b1, 4'b0000, 1, 0, 0, 2, 1'b1};
      vecs[1] = '{8'h86, 1, {8'h00, 8'h00, 8'hAA}, 1'b1, 4'b0011, 0, 0, 0, 0, 1'b0};
      vecs[2] = '{8'h85, 3, {8'h3C, 8'hA5, 8'h80}, 1'b1, 4'b0000, 0, 1, 3, 0, 1'b1};
      vecs[3] = '{8'h84, 2, {8'h00, 8'h77, 8'h5A}, 1'b0, 4'b0110, 1, 0, 0, 1, 1'b1};
      vecs[4] = '{8'h84, 1, {8'h00, 8'h00, 8'hFF}, 1'b1, 4'b0000, 1, 0, 0, 1, 1'b1};
      vecs[5] = '{8'h85, 2, {8'h00, 8'h7E, 8'h00}, 1'b1, 4'b0000, 0, 1, 2, 0, 1'b1};
      vecs[6] = '{8'h04, 1, {8'h00, 8'h00, 8'h55}, 1'b1, 4'b0011, 0, 0, 0, 0, 1'b0};
      vecs[7] = '{8'h84, 3, {8'h80, 8'h01, 8'h00}, 1'b1, 4'b0000, 1, 0, 0, 3, 1'b1};

      rst = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      i2c_write_ready = 1'b0;
      qwait(4);
      chk("reset_sda_oe", 32'(sda_oe), 32'd0);
      chk("reset_write", 32'(i2c_write), 32'd0);
      chk("reset_read", 32'(i2c_read), 32'd0);
      chk("reset_wvalid", 32'(i2c_write_valid), 32'd0);
      chk("reset_wdata", 32'(i2c_write_data), 32'd0);
      chk("reset_rready", 32'(i2c_read_ready), 32'd0);
      rst = 1'b0;
      qwait(2 * Q);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Repeated START: write then read with nothing available to send
      wr0 = c_wr; rd0 = c_rd; rdy0 = c_rdy;
      i2c_write_ready = 1'b1;
      i2c_start();
      wbyte(8'h84, ack);
      chk("rs_addr_w_ack", 32'(ack), 32'd0);
      wbyte(8'h01, ack);
      chk("rs_data_ack", 32'(ack), 32'd0);
      exp_wq.push_back(8'h01);
      chk("rs_wr_before_sr", 32'(c_wr - wr0), 32'd1);
      i2c_start();
      wbyte(8'h85, ack);
      chk("rs_addr_r_ack", 32'(ack), 32'd0);
      rbyte(1'b1, got);
      chk("rs_empty_byte", 32'(got), 32'hFF);
      i2c_stop();
      chk("rs_rd_pulses", 32'(c_rd - rd0), 32'd1);
      chk("rs_ready_pulses", 32'(c_rdy - rdy0), 32'd0);
      check_writes("rs");

      // Reset while the address ACK is being driven
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_xfer(i == 7 || i == 2);
      chk("rst_ack_driven", 32'(sda_oe), 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_oe_release", 32'(sda_oe), 32'd0);
      qwait(3);
      rst = 1'b0;
      sda_m = 1'b1;
      scl_m = 1'b1;
      qwait(2 * Q);
      run_vec('{8'h84, 1, {8'h00, 8'h00, 8'h33}, 1'b1, 4'b0000, 1, 0, 0, 1, 1'b1}, "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
